// File: rtl/irrigation_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_countdown_timer
// Description : BCD mm:ss countdown (00:00-39:59) that reloads a clamped
//               preset, decrements on each 1 Hz tick and pulses on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_countdown_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_reset,
    input  logic       tick_1hz,
    input  logic       pause,
    input  logic [1:0] preset_minutes_d,
    input  logic [3:0] preset_minutes_u,
    input  logic [2:0] preset_seconds_d,
    input  logic [3:0] preset_seconds_u,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       running,
    output logic       expired
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] r_state;
    logic [1:0] r_min_d;
    logic [3:0] r_min_u;
    logic [2:0] r_sec_d;
    logic [3:0] r_sec_u;
    logic       r_running;
    logic       r_expired;

    logic [1:0] w_state_nxt;
    logic [1:0] w_min_d_nxt;
    logic [3:0] w_min_u_nxt;
    logic [2:0] w_sec_d_nxt;
    logic [3:0] w_sec_u_nxt;
    logic       w_running_nxt;
    logic       w_expired_nxt;
    logic       w_is_zero;
    logic       w_is_one;

    assign w_is_zero = (r_min_d == 2'd0) && (r_min_u == 4'd0) &&
                       (r_sec_d == 3'd0) && (r_sec_u == 4'd0);
    assign w_is_one  = (r_min_d == 2'd0) && (r_min_u == 4'd0) &&
                       (r_sec_d == 3'd0) && (r_sec_u == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_min_d   <= 2'd0;
            r_min_u   <= 4'd0;
            r_sec_d   <= 3'd0;
            r_sec_u   <= 4'd0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_min_d   <= w_min_d_nxt;
            r_min_u   <= w_min_u_nxt;
            r_sec_d   <= w_sec_d_nxt;
            r_sec_u   <= w_sec_u_nxt;
            r_running <= w_running_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_min_d_nxt   = r_min_d;
        w_min_u_nxt   = r_min_u;
        w_sec_d_nxt   = r_sec_d;
        w_sec_u_nxt   = r_sec_u;
        w_expired_nxt = 1'b0;

        // A load request overrides every state and any same-cycle tick
        if (timer_reset) begin
            w_state_nxt = S_LOAD;
            w_min_d_nxt = preset_minutes_d;
            w_min_u_nxt = (preset_minutes_u > 4'd9) ? 4'd9 : preset_minutes_u;
            w_sec_d_nxt = (preset_seconds_d > 3'd5) ? 3'd5 : preset_seconds_d;
            w_sec_u_nxt = (preset_seconds_u > 4'd9) ? 4'd9 : preset_seconds_u;
        end else begin
            case (r_state)
                S_LOAD: w_state_nxt = w_is_zero ? S_DONE : S_RUN;
                S_RUN: begin
                    if (w_is_zero) begin
                        w_state_nxt = S_DONE;
                    end else if (tick_1hz && !pause) begin
                        if (w_is_one) begin
                            w_sec_u_nxt   = 4'd0;
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end else if (r_sec_u != 4'd0) begin
                            w_sec_u_nxt = r_sec_u - 4'd1;
                        end else begin
                            w_sec_u_nxt = 4'd9;
                            if (r_sec_d != 3'd0) begin
                                w_sec_d_nxt = r_sec_d - 3'd1;
                            end else begin
                                w_sec_d_nxt = 3'd5;
                                if (r_min_u != 4'd0) begin
                                    w_min_u_nxt = r_min_u - 4'd1;
                                end else begin
                                    w_min_u_nxt = 4'd9;
                                    w_min_d_nxt = r_min_d - 2'd1;
                                end
                            end
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end

        w_running_nxt = (w_state_nxt == S_RUN) && !pause;
    end

    assign minutes_d = r_min_d;
    assign minutes_u = r_min_u;
    assign seconds_d = r_sec_d;
    assign seconds_u = r_sec_u;
    assign running   = r_running;
    assign expired   = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irrigation_countdown_timer
// Description : Self-checking bench comparing the timer against a
//               seconds-count reference model under directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irrigation_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       timer_reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] preset_minutes_d = 2'd0;
    logic [3:0] preset_minutes_u = 4'd0;
    logic [2:0] preset_seconds_d = 3'd0;
    logic [3:0] preset_seconds_u = 4'd0;
    logic [1:0] minutes_d;
    logic [3:0] minutes_u;
    logic [2:0] seconds_d;
    logic [3:0] seconds_u;
    logic       running;
    logic       expired;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining time as plain seconds plus a phase
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;
    int   m_phase   = P_IDLE;
    int   m_secs    = 0;
    logic m_running = 1'b0;
    logic m_expired = 1'b0;

    irrigation_countdown_timer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .timer_reset      (timer_reset),
        .tick_1hz         (tick_1hz),
        .pause            (pause),
        .preset_minutes_d (preset_minutes_d),
        .preset_minutes_u (preset_minutes_u),
        .preset_seconds_d (preset_seconds_d),
        .preset_seconds_u (preset_seconds_u),
        .minutes_d        (minutes_d),
        .minutes_u        (minutes_u),
        .seconds_d        (seconds_d),
        .seconds_u        (seconds_u),
        .running          (running),
        .expired          (expired)
    );

    always #5 clk = ~clk;

    wire [14:0] dut_vec = {minutes_d, minutes_u, seconds_d, seconds_u, running, expired};

    function automatic logic [14:0] exp_vec();
        int s;
        s = m_secs;
        return {2'(s / 600), 4'((s / 60) % 10), 3'((s % 60) / 10), 4'(s % 10),
                m_running, m_expired};
    endfunction

    function automatic int preset_secs();
        int mu, sd, su;
        mu = (preset_minutes_u > 4'd9) ? 9 : int'(preset_minutes_u);
        sd = (preset_seconds_d > 3'd5) ? 5 : int'(preset_seconds_d);
        su = (preset_seconds_u > 4'd9) ? 9 : int'(preset_seconds_u);
        return int'(preset_minutes_d) * 600 + mu * 60 + sd * 10 + su;
    endfunction

    task automatic set_preset(input int md, input int mu, input int sd, input int su);
        preset_minutes_d = 2'(md);
        preset_minutes_u = 4'(mu);
        preset_seconds_d = 3'(sd);
        preset_seconds_u = 4'(su);
    endtask

    // One clock with the given inputs; model advances on the same edge
    task automatic step(input logic tr, input logic tk, input logic ps);
        int ps_secs;
        timer_reset = tr;
        tick_1hz    = tk;
        pause       = ps;
        ps_secs     = preset_secs();
        @(posedge clk);
        m_expired = 1'b0;
        if (tr) begin
            m_phase = P_LOAD;
            m_secs  = ps_secs;
        end else if (m_phase == P_LOAD) begin
            m_phase = (m_secs == 0) ? P_DONE : P_RUN;
        end else if (m_phase == P_RUN && tk && !ps) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_phase   = P_DONE;
                m_expired = 1'b1;
            end
        end
        m_running = (m_phase == P_RUN) && !ps;
        #1;
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_secs    = 0;
        m_running = 1'b0;
        m_expired = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== 15'd0) $display("FAIL reset_state got %h want %h", dut_vec, 15'd0);
        else n_pass++;
        #3 rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL idle_hold got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_load_count();
        set_preset(0, 1, 0, 2);
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL load_0102 got %h want %h", dut_vec, exp_vec());
        else n_pass++;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (dut_vec !== exp_vec() || running !== 1'b1)
                $display("FAIL count_tick%0d got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({minutes_d, minutes_u, seconds_d, seconds_u} !== {2'd0, 4'd0, 3'd5, 4'd9})
            $display("FAIL count_0059 got %h want 00:59",
                     {minutes_d, minutes_u, seconds_d, seconds_u});
        else n_pass++;
    endtask

    task automatic test_full_borrow();
        set_preset(1, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL borrow_1000 got %h want %h", dut_vec, exp_vec());
        else n_pass++;
        set_preset(0, 0, 1, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL borrow_0010 got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_expiry();
        int pulses;
        pulses = 0;
        set_preset(0, 0, 0, 2);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL expiry_tick%0d got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (expired === 1'b1) pulses++;
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL done_hold%0d got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL extra_pulses got %0d want 0", pulses);
        else n_pass++;
    endtask

    task automatic test_conflicts();
        set_preset(0, 5, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        set_preset(0, 2, 3, 0);
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reload_on_tick got %h want %h", dut_vec, exp_vec());
        else n_pass++;
        set_preset(0, 5, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL pause_hold%0d got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL after_pause got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_clamp_zero();
        set_preset(3, 15, 7, 12);
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({minutes_d, minutes_u, seconds_d, seconds_u} !== {2'd3, 4'd9, 3'd5, 4'd9})
            $display("FAIL clamp_3959 got %h want 39:59",
                     {minutes_d, minutes_u, seconds_d, seconds_u});
        else n_pass++;
        set_preset(0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (dut_vec !== exp_vec() || running !== 1'b0 || expired !== 1'b0)
                $display("FAIL zero_preset%0d got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        set_preset(1, 2, 3, 4);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 15'd0) $display("FAIL async_reset got %h want %h", dut_vec, 15'd0);
        else n_pass++;
        #1 rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL post_reset_idle got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic tr, tk, ps;
        for (int i = 0; i < 400; i++) begin
            set_preset(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) set_preset(0, 0, 0, int'($urandom_range(0, 3)));
            tr = ($urandom_range(0, 24) == 0);
            tk = ($urandom_range(0, 1) == 0);
            ps = ($urandom_range(0, 5) == 0);
            step(tr, tk, ps);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random_%0d got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_full_borrow();
        test_expiry();
        test_conflicts();
        test_clamp_zero();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
